// File: rtl/draw_scheduler_pkg.sv
// rtl/draw_scheduler_pkg.sv - shared state encodings and screen constants for the draw scheduler
`ifndef DRAW_TRANSPARENT_COLOUR
`define DRAW_TRANSPARENT_COLOUR 3'b000
`endif

package draw_scheduler_pkg;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_BG   = 2'd1,
    DS_GAP  = 2'd2,
    DS_FG   = 2'd3
  } ds_state_e;

  localparam logic [2:0] DRAW_TRANSPARENT_COLOUR = `DRAW_TRANSPARENT_COLOUR;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

endpackage

// File: rtl/draw_scheduler_phase_timer.sv
// rtl/draw_scheduler_phase_timer.sv - loadable up-counter with terminal-count flag for gap and timeout
module draw_scheduler_phase_timer #(
  parameter int W = 19
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/draw_scheduler.sv
// rtl/draw_scheduler.sv - per-frame BG/FG drawer sequencer and pixel-mux control
// Optional feature macro: TRANSPARENT_EN (foreground colour-keyed plot gate).
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 400000,
  parameter int OVR_W      = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             frame_tick,
  input  logic             bg_done,
  input  logic             fg_done,
  input  logic [2:0]       fg_colour,
  output logic             bg_start,
  output logic             fg_start,
  output logic             background_sel,
  output logic             foreground_sel,
  output logic             plot_gate,
  output logic             busy,
  output logic             timeout_err,
  output logic [OVR_W-1:0] overrun_cnt
);

  localparam int CW = $clog2(TIMEOUT + 1);

  ds_state_e      state_q, state_d;
  logic           pending_q;
  logic [CW-1:0]  phase_cnt, term;
  logic           tc, done_in, done_ok, phase_end, in_run;

  // One counter serves both the gap length and the per-phase watchdog.
  assign term = (state_q == DS_GAP) ? CW'(GAP_CYCLES - 1) : CW'(TIMEOUT - 1);

  draw_scheduler_phase_timer #(.W(CW)) u_timer (
    .clock  (clock),
    .resetn (resetn),
    .clear  (state_d != state_q),
    .en     (state_q != DS_IDLE),
    .term   (term),
    .count  (phase_cnt),
    .tc     (tc)
  );

  assign in_run    = (state_q == DS_BG) || (state_q == DS_FG);
  assign done_in   = (state_q == DS_BG) ? bg_done : fg_done;
  // Done on the start-pulse cycle may be stale from the previous pass.
  assign done_ok   = done_in && (phase_cnt != '0);
  assign phase_end = done_ok || tc;
  assign busy      = (state_q != DS_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (frame_tick || pending_q) state_d = DS_BG;
      DS_BG:   if (phase_end) state_d = DS_GAP;
      DS_GAP:  if (tc) state_d = DS_FG;
      DS_FG:   if (phase_end) state_d = DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= DS_IDLE;
      background_sel <= 1'b0;
      foreground_sel <= 1'b0;
      bg_start       <= 1'b0;
      fg_start       <= 1'b0;
      pending_q      <= 1'b0;
      overrun_cnt    <= '0;
      timeout_err    <= 1'b0;
    end else begin
      state_q        <= state_d;
      background_sel <= (state_d == DS_BG);
      foreground_sel <= (state_d == DS_FG);
      bg_start       <= (state_q == DS_IDLE) && (state_d == DS_BG);
      fg_start       <= (state_q == DS_GAP) && (state_d == DS_FG);
      if (state_q != DS_IDLE) begin
        if (frame_tick) begin
          pending_q <= 1'b1;
          if (overrun_cnt != '1) overrun_cnt <= overrun_cnt + 1'b1;
        end
      end else begin
        pending_q <= 1'b0;
      end
      if (in_run && tc && !done_ok) timeout_err <= 1'b1;
    end
  end

`ifdef TRANSPARENT_EN
  assign plot_gate = background_sel |
                     (foreground_sel & (fg_colour != DRAW_TRANSPARENT_COLOUR));
`else
  logic unused_colour;
  assign unused_colour = ^fg_colour;
  assign plot_gate     = background_sel | foreground_sel;
`endif

endmodule

// File: tb/tb_draw_scheduler.sv
// tb/tb_draw_scheduler.sv - scoreboard bench for draw_scheduler
module tb_draw_scheduler;

  localparam int TMO = 24;
`ifdef TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif
  localparam logic [12:0] M_LV  = 13'h0F00;
  localparam logic [12:0] M_OVR = 13'h00FF;
  localparam logic [12:0] M_TMO = 13'h1000;
  localparam logic [12:0] M_ALL = 13'h1FFF;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0, bg_done = 1'b0, fg_done = 1'b0;
  logic [2:0] fg_colour = 3'b101;
  logic       bg_start, fg_start, background_sel, foreground_sel, plot_gate, busy, timeout_err;
  logic [7:0] overrun_cnt;

  draw_scheduler #(.GAP_CYCLES(2), .TIMEOUT(TMO), .OVR_W(8)) dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .bg_done(bg_done),
    .fg_done(fg_done), .fg_colour(fg_colour), .bg_start(bg_start), .fg_start(fg_start),
    .background_sel(background_sel), .foreground_sel(foreground_sel), .plot_gate(plot_gate),
    .busy(busy), .timeout_err(timeout_err), .overrun_cnt(overrun_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    string       name;
    logic [12:0] exp;
    logic [12:0] mask;
  } chk_t;

  chk_t chk_q[$];
  int   bg_q[$];
  int   fg_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   ign_starts = 1'b0;
  bit   tog_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [2:0] col_at(input int c);
    return (tog_en && (c % 2 == 1)) ? 3'b000 : 3'b101;
  endfunction

  function automatic bit exp_plot(input int c, input bit b, input bit f);
    return b | (f & (!TRANSP || col_at(c) != 3'b000));
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    fg_colour = col_at(cyc);
  endtask

  task automatic push_chk(input int c, input string n, input logic [12:0] e, input logic [12:0] m);
    chk_t x;
    x.cyc = c; x.name = n; x.exp = e; x.mask = m;
    chk_q.push_back(x);
  endtask

  // Monitor: snapshot at the falling edge, retire every expectation due this cycle.
  always @(negedge clock) begin
    logic [12:0] snap;
    snap = {timeout_err, busy, plot_gate, foreground_sel, background_sel, overrun_cnt};
    total++;
    if (background_sel && foreground_sel) begin
      bad++;
      $display("FAIL sel_onehot cyc=%0d got both selects high, need at most one", cyc);
    end
    for (int i = chk_q.size() - 1; i >= 0; i--) begin
      if (chk_q[i].cyc <= cyc) begin
        total++;
        if (chk_q[i].cyc < cyc) begin
          bad++;
          $display("FAIL %s cyc=%0d expectation never sampled", chk_q[i].name, chk_q[i].cyc);
        end else if ((snap & chk_q[i].mask) !== (chk_q[i].exp & chk_q[i].mask)) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%h exp=%h mask=%h", chk_q[i].name, cyc,
                   snap & chk_q[i].mask, chk_q[i].exp & chk_q[i].mask, chk_q[i].mask);
        end
        chk_q.delete(i);
      end
    end
    if (!ign_starts) begin
      if (bg_start) begin
        total++;
        if (bg_q.size() == 0 || bg_q[0] != cyc) begin
          bad++;
          $display("FAIL bg_start cyc=%0d got unexpected pulse, next expected=%0d", cyc,
                   bg_q.size() ? bg_q[0] : -1);
        end else void'(bg_q.pop_front());
      end
      if (bg_q.size() && bg_q[0] < cyc) begin
        total++; bad++;
        $display("FAIL bg_start cyc=%0d got no pulse, need pulse", bg_q[0]);
        void'(bg_q.pop_front());
      end
      if (fg_start) begin
        total++;
        if (fg_q.size() == 0 || fg_q[0] != cyc) begin
          bad++;
          $display("FAIL fg_start cyc=%0d got unexpected pulse, next expected=%0d", cyc,
                   fg_q.size() ? fg_q[0] : -1);
        end else void'(fg_q.pop_front());
      end
      if (fg_q.size() && fg_q[0] < cyc) begin
        total++; bad++;
        $display("FAIL fg_start cyc=%0d got no pulse, need pulse", fg_q[0]);
        void'(fg_q.pop_front());
      end
    end
  end

  // Frame whose BG phase starts at t+1: bl BG cycles, 2 gap cycles, fl FG cycles, then IDLE.
  task automatic exp_frame(input int t, input int bl, input int fl);
    int e;
    bit b, f;
    e = t + bl + fl + 3;
    bg_q.push_back(t + 1);
    fg_q.push_back(t + bl + 3);
    for (int c = t + 1; c <= e; c++) begin
      b = (c <= t + bl);
      f = (c >= t + bl + 3) && (c < e);
      push_chk(c, "frame", {1'b0, (c < e), exp_plot(c, b, f), f, b, 8'h00}, M_LV);
    end
  endtask

  task automatic run_frame(input int bl, input int fl, input int nt,
                           input bit early, input bit drive_bg, input bit tx);
    exp_frame(cyc, bl, fl);
    step();
    for (int i = 1; i < bl; i++) begin
      frame_tick = ((i == 2) && nt >= 1) || ((i == 4) && nt >= 2);
      bg_done    = early && (i == 1);
      step();
    end
    frame_tick = 1'b0;
    bg_done    = drive_bg;
    step();
    bg_done = 1'b0;
    repeat (fl + 1) step();
    frame_tick = tx;
    fg_done    = 1'b1;
    step();
    fg_done    = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0; frame_tick = 1'b0; bg_done = 1'b0; fg_done = 1'b0;
    step();
    push_chk(cyc, "reset_state", 13'h0000, M_ALL);
    step();
    resetn = 1'b1;
    step();
  endtask

  initial begin
    int t, e;
    do_reset();

    // 1: nominal frame with a stale bg_done on the start cycle
    frame_tick = 1'b1;
    run_frame(10, 20, 0, 1'b1, 1'b1, 1'b0);
    push_chk(cyc, "t1_no_overrun", 13'h0000, M_OVR | M_TMO);
    step(); step();

    // 2: two ticks in BG, then a tick on the FG exit cycle
    t = cyc;
    push_chk(t + 2, "t2_ovr0", 13'h0000, M_OVR);
    push_chk(t + 3, "t2_ovr1", 13'h0001, M_OVR);
    push_chk(t + 5, "t2_ovr2", 13'h0002, M_OVR);
    frame_tick = 1'b1;
    run_frame(10, 5, 2, 1'b0, 1'b1, 1'b0);
    push_chk(cyc, "t2_ovr2_end", 13'h0002, M_OVR);
    e = cyc + 4 + 4 + 3;
    run_frame(4, 4, 0, 1'b0, 1'b1, 1'b1);
    push_chk(e, "t2_ovr_exit_tick", 13'h0003, M_OVR);
    run_frame(5, 3, 0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) push_chk(cyc + k, "t2_idle_after", 13'h0000, M_LV);
    repeat (4) step();

    // 3: background never finishes -> watchdog, sticky error
    do_reset();
    t = cyc;
    push_chk(t + TMO, "t3_tmo_before", 13'h0000, M_TMO);
    push_chk(t + TMO + 1, "t3_tmo_set", 13'h1000, M_TMO);
    frame_tick = 1'b1;
    run_frame(TMO, 5, 0, 1'b0, 1'b0, 1'b0);
    frame_tick = 1'b1;
    run_frame(6, 6, 0, 1'b0, 1'b1, 1'b0);
    push_chk(cyc, "t3_tmo_sticky", 13'h1000, M_TMO);
    step();

    // 5: reset in the middle of FG_RUN, then a fresh frame
    do_reset();
    t = cyc;
    bg_q.push_back(t + 1);
    fg_q.push_back(t + 6);
    push_chk(t + 7, "t5_in_fg", {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00}, M_LV);
    push_chk(t + 8, "t5_reset_mid_fg", 13'h0000, M_ALL);
    frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    step(); step();
    bg_done = 1'b1;
    step(); bg_done = 1'b0;
    repeat (4) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
    frame_tick = 1'b1;
    run_frame(5, 5, 0, 1'b0, 1'b1, 1'b0);
    step();

    // 6: foreground colour toggling against the plot gate
    tog_en = 1'b1;
    frame_tick = 1'b1;
    run_frame(4, 8, 0, 1'b0, 1'b1, 1'b0);
    tog_en = 1'b0;
    step(); step();

    // 4: ticks every cycle while drawers stall -> saturation
    do_reset();
    ign_starts = 1'b1;
    t = cyc;
    push_chk(t + 11, "t4_ovr10", 13'h000A, M_OVR);
    push_chk(t + 300, "t4_ovr_sat", 13'h00FF, M_OVR);
    push_chk(t + 400, "t4_ovr_hold", 13'h00FF, M_OVR);
    frame_tick = 1'b1;
    repeat (402) step();
    frame_tick = 1'b0;
    repeat (3) step();

    foreach (chk_q[i]) begin
      total++; bad++;
      $display("FAIL %s cyc=%0d got no sample, need one", chk_q[i].name, chk_q[i].cyc);
    end
    foreach (bg_q[i]) begin
      total++; bad++;
      $display("FAIL bg_start_left cyc=%0d got no pulse, need pulse", bg_q[i]);
    end
    foreach (fg_q[i]) begin
      total++; bad++;
      $display("FAIL fg_start_left cyc=%0d got no pulse, need pulse", fg_q[i]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
